// File: rtl/baby_pkg.sv
// -----------------------------------------------------------------------------
// baby_pkg
// Shared definitions for the Manchester Baby store slice.
//   STORE_ADDR_W / STORE_DATA_W : default store geometry (32 words x 32 bits)
//   load_state_t                : loader FSM states
// -----------------------------------------------------------------------------
package baby_pkg;

    localparam int STORE_ADDR_W = 5;
    localparam int STORE_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage : baby_pkg

// File: rtl/baby_store_loader.sv
// -----------------------------------------------------------------------------
// baby_store_loader
// Word-stream loader that fills the whole store from address 0 upward.
//   clk_i, reset_ni   : clock, asynchronous active-low reset
//   load_start_i      : pulse; (re)starts a full load at address 0
//   load_valid_i/_data: incoming word stream
//   load_ready_o      : loader accepts a word this cycle
//   load_done_o       : one-cycle pulse after the last word is written
//   cpu_hold_o        : high while a load is in progress (LOAD and DONE)
//   state_o           : current FSM state (also gates CPU writes in the top)
//   we_o/waddr_o/wdata_o : write request to the storage array
//
// Handshake: a word transfers on any rising edge where load_valid_i and
// load_ready_o are both 1. load_ready_o is registered and never depends on
// load_valid_i; the source may hold or drop valid freely between transfers.
// -----------------------------------------------------------------------------
module baby_store_loader
    import baby_pkg::*;
#(
    parameter int ADDR_W = STORE_ADDR_W,
    parameter int DATA_W = STORE_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              cpu_hold_o,
    output load_state_t       state_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, done_q, hold_q;
    logic              accept;

    assign accept = load_valid_i & ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    // Pointer wraps to 0 naturally after the last address.
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
        // A start pulse in any state restarts the load; a word accepted in
        // the same cycle is still written at the old pointer (see we_o).
        if (load_start_i) begin
            state_d = LOAD;
            ptr_d   = '0;
        end
    end

    // Status outputs are registered decodes of the next state, so they track
    // the state register exactly and reset to 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == LOAD);
            done_q  <= (state_d == DONE);
            hold_q  <= (state_d != IDLE);
        end
    end

    assign load_ready_o = ready_q;
    assign load_done_o  = done_q;
    assign cpu_hold_o   = hold_q;
    assign state_o      = state_q;
    assign we_o         = accept;
    assign waddr_o      = ptr_q;
    assign wdata_o      = load_data_i;

endmodule : baby_store_loader

// File: rtl/baby_store.sv
// -----------------------------------------------------------------------------
// baby_store
// Main store for the Manchester Baby: 2^ADDR_W words of DATA_W bits, served to
// the CPU with synchronous reads and gated writes, plus a full-store loader.
//   clk_i, reset_ni : clock, asynchronous active-low reset (clears the store)
//   ram_addr_i      : CPU word address
//   ram_data_i      : CPU write data
//   ram_rw_en_i     : 1 = write, 0 = read
//   ram_data_o      : registered read data (1-cycle latency, old-data on RAW)
//   load_*          : loader stream interface (see baby_store_loader)
//   cpu_hold_o      : hold the CPU in reset while a load is in progress
// -----------------------------------------------------------------------------
module baby_store
    import baby_pkg::*;
#(
    parameter int ADDR_W = STORE_ADDR_W,
    parameter int DATA_W = STORE_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [DATA_W-1:0] ram_data_i,
    input  logic              ram_rw_en_i,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic              load_start_i,
    input  logic              load_valid_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              cpu_hold_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    load_state_t       ld_state;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_waddr;
    logic [DATA_W-1:0] ld_wdata;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    baby_store_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_done_o  (load_done_o),
        .cpu_hold_o   (cpu_hold_o),
        .state_o      (ld_state),
        .we_o         (ld_we),
        .waddr_o      (ld_waddr),
        .wdata_o      (ld_wdata)
    );

    // Single write port. The loader only writes in LOAD and the CPU only in
    // IDLE, so the two sources never collide.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ram_addr_i;
        wr_data = ram_data_i;
        if (ld_we) begin
            wr_en   = 1'b1;
            wr_addr = ld_waddr;
            wr_data = ld_wdata;
        end else if ((ld_state == IDLE) && ram_rw_en_i) begin
            wr_en   = 1'b1;
        end
    end

    // Read samples the array before this edge's write lands, which gives
    // old-data behaviour on a same-address read-during-write.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ram_data_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ram_data_o <= mem_q[ram_addr_i];
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

endmodule : baby_store

// File: tb/tb_baby_store.sv
module tb_baby_store;

  logic        clk;
  logic        reset_ni;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rw_en;
  logic [31:0] ram_rdata;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  // Behavioural model: memory contents, whether a load is running, how many
  // words it has taken, and whether the done cycle is pending.
  logic [31:0] m_mem [32];
  bit          m_loading;
  bit          m_done;
  int          m_count;
  logic [31:0] exp_q [$];

  int cnt_ready, cnt_done, cnt_hold;

  baby_store dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .ram_addr_i   (ram_addr),
    .ram_data_i   (ram_wdata),
    .ram_rw_en_i  (ram_rw_en),
    .ram_data_o   (ram_rdata),
    .load_start_i (load_start),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .load_done_o  (load_done),
    .cpu_hold_o   (cpu_hold)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counts();
    cnt_ready = 0;
    cnt_done  = 0;
    cnt_hold  = 0;
  endtask

  task automatic idle_inputs();
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_rw_en  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
  endtask

  // One clock: inputs are already driven (at the negedge). Advance the model
  // across the posedge, then compare every output at the next negedge.
  task automatic tick(input string tag);
    logic [31:0] rd_exp;
    bit          acc;
    bit          cpu_wr;
    bit          exp_ready, exp_done, exp_hold;
    rd_exp = m_mem[ram_addr];
    acc    = m_loading && load_valid;
    cpu_wr = !m_loading && !m_done && ram_rw_en;
    @(posedge clk);
    if (acc) begin
      m_mem[m_count] = load_data;
      exp_q.push_back(load_data);
    end else if (cpu_wr) begin
      m_mem[ram_addr] = ram_wdata;
    end
    if (load_start) begin
      m_loading = 1;
      m_done    = 0;
      m_count   = 0;
      exp_q.delete();
    end else if (acc && m_count == 31) begin
      m_loading = 0;
      m_done    = 1;
      m_count   = 0;
    end else begin
      if (acc) m_count++;
      m_done = 0;
    end
    exp_ready = m_loading;
    exp_done  = m_done;
    exp_hold  = m_loading || m_done;
    @(negedge clk);
    checks += 4;
    if (ram_rdata !== rd_exp) begin
      errors++;
      $display("FAIL %s ram_data_o: got %08h expected %08h", tag, ram_rdata, rd_exp);
    end
    if (load_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s load_ready_o: got %b expected %b", tag, load_ready, exp_ready);
    end
    if (load_done !== exp_done) begin
      errors++;
      $display("FAIL %s load_done_o: got %b expected %b", tag, load_done, exp_done);
    end
    if (cpu_hold !== exp_hold) begin
      errors++;
      $display("FAIL %s cpu_hold_o: got %b expected %b", tag, cpu_hold, exp_hold);
    end
    if (load_ready === 1'b1) cnt_ready++;
    if (load_done  === 1'b1) cnt_done++;
    if (cpu_hold   === 1'b1) cnt_hold++;
  endtask

  // Called at a negedge or mid-cycle; asserts reset and releases it later.
  task automatic do_reset();
    reset_ni = 1'b0;
    idle_inputs();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_loading = 0;
    m_done    = 0;
    m_count   = 0;
    exp_q.delete();
    #1;
    checks++;
    if ({ram_rdata, load_ready, load_done, cpu_hold} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%08h rdy=%b done=%b hold=%b expected all 0",
               ram_rdata, load_ready, load_done, cpu_hold);
    end
    @(negedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      ram_addr   = 5'(a);
      ram_rw_en  = 1'b0;
      load_valid = 1'b0;
      load_start = 1'b0;
      tick(tag);
    end
  endtask

  // Read the store back and match it in order against the accepted words.
  task automatic read_queue(input string tag);
    logic [31:0] w;
    checks++;
    if (exp_q.size() != 32) begin
      errors++;
      $display("FAIL %s word_count: got %0d expected 32", tag, exp_q.size());
    end
    for (int a = 0; a < 32; a++) begin
      ram_addr  = 5'(a);
      ram_rw_en = 1'b0;
      tick(tag);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        checks++;
        if (ram_rdata !== w) begin
          errors++;
          $display("FAIL %s seq_word[%0d]: got %08h expected %08h", tag, a, ram_rdata, w);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    read_all("reset_read");
  endtask

  task automatic test_cpu_rw();
    ram_addr  = 5'd7;
    ram_wdata = 32'hDEADBEEF;
    ram_rw_en = 1'b1;
    tick("raw_same_cycle");
    checks++;
    if (ram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL raw_old_value: got %08h expected 00000000", ram_rdata);
    end
    ram_rw_en = 1'b0;
    tick("read_after_write");
    checks++;
    if (ram_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_7: got %08h expected deadbeef", ram_rdata);
    end
    for (int i = 0; i < 80; i++) begin
      ram_addr  = 5'($urandom_range(0, 31));
      ram_wdata = $urandom;
      ram_rw_en = 1'($urandom_range(0, 1));
      tick("cpu_random");
    end
    ram_rw_en = 1'b0;
    read_all("cpu_readback");
  endtask

  task automatic test_full_load();
    clear_counts();
    load_start = 1'b1;
    tick("full_start");
    load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(i) * 32'h01010101;
      tick("full_word");
    end
    load_valid = 1'b0;
    tick("full_done");
    tick("full_after");
    checks += 3;
    if (cnt_ready != 32) begin
      errors++;
      $display("FAIL full_ready_cycles: got %0d expected 32", cnt_ready);
    end
    if (cnt_done != 1) begin
      errors++;
      $display("FAIL full_done_pulses: got %0d expected 1", cnt_done);
    end
    if (cnt_hold != 33) begin
      errors++;
      $display("FAIL full_hold_cycles: got %0d expected 33", cnt_hold);
    end
    read_queue("full_readback");
  endtask

  task automatic test_stalled_load();
    int cyc;
    clear_counts();
    load_start = 1'b1;
    tick("stall_start");
    load_start = 1'b0;
    cyc = 0;
    while (cnt_done == 0 && cyc < 200) begin
      load_valid = cyc[0];
      load_data  = $urandom;
      tick("stall_word");
      cyc++;
    end
    load_valid = 1'b0;
    checks++;
    if (cnt_done != 1) begin
      errors++;
      $display("FAIL stall_timeout: got done=%0d after %0d cycles expected 1", cnt_done, cyc);
    end
    tick("stall_after");
    read_queue("stall_readback");
  endtask

  task automatic test_cpu_write_during_load();
    load_start = 1'b1;
    tick("cwl_start");
    load_start = 1'b0;
    ram_addr   = 5'd3;
    ram_wdata  = 32'hFFFFFFFF;
    ram_rw_en  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(i) * 32'h01010101;
      tick("cwl_word");
    end
    load_valid = 1'b0;
    tick("cwl_done");
    ram_rw_en = 1'b0;
    tick("cwl_read3");
    checks++;
    if (ram_rdata !== 32'h03030303) begin
      errors++;
      $display("FAIL cwl_addr3: got %08h expected 03030303", ram_rdata);
    end
    read_all("cwl_readback");
  endtask

  task automatic test_restart();
    clear_counts();
    load_start = 1'b1;
    tick("rst_start");
    load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      tick("rst_first");
    end
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = $urandom;
    tick("rst_restart");
    load_start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      tick("rst_second");
    end
    checks++;
    if (cnt_done != 0) begin
      errors++;
      $display("FAIL restart_early_done: got %0d pulses expected 0", cnt_done);
    end
    load_data = $urandom;
    tick("rst_last");
    load_valid = 1'b0;
    checks++;
    if (cnt_done != 1) begin
      errors++;
      $display("FAIL restart_done: got %0d pulses expected 1", cnt_done);
    end
    tick("rst_after");
    read_queue("restart_readback");
  endtask

  task automatic test_abort();
    load_start = 1'b1;
    tick("abort_start");
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom | 32'h1;
      tick("abort_word");
    end
    #2;
    do_reset();
    clear_counts();
    read_all("abort_readback");
    checks++;
    if (cnt_done != 0 || cnt_hold != 0) begin
      errors++;
      $display("FAIL abort_no_done: got done=%0d hold=%0d expected 0 0", cnt_done, cnt_hold);
    end
  endtask

  initial begin
    reset_ni = 1'b1;
    idle_inputs();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_loading = 0;
    m_done    = 0;
    m_count   = 0;
    @(negedge clk);
    test_reset();
    test_cpu_rw();
    test_full_load();
    test_stalled_load();
    test_cpu_write_during_load();
    test_restart();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_baby_store

// File: doc/baby_store.md
# baby_store

Main store for the Manchester Baby core: the responder on the CPU's `ram_*` interface, holding 32 words of 32 bits. It serves the CPU's reads and writes. It also provides a word-stream loader that fills the whole store from an external source, such as a host bridge or switch panel, while the CPU is held off. It sits beside `main` in the top-level shell and connects directly to the CPU's `ram_addr_o`, `ram_data_o`, `ram_data_i` and `ram_rw_en_o`.

## Interface
Parameters:
- `ADDR_W`, 5: store address width; depth is 2^ADDR_W words.
- `DATA_W`, 32: word width.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`, in, 1: store clock, same domain as the CPU clock tree.
- `reset_ni`, in, 1: asynchronous active-low reset.
- `ram_addr_i`, in, ADDR_W: CPU word address.
- `ram_data_i`, in, DATA_W: CPU write data, from the CPU's `ram_data_o`.
- `ram_rw_en_i`, in, 1: 1 = write, 0 = read.
- `ram_data_o`, out, DATA_W: read data, to the CPU's `ram_data_i`.
- `load_start_i`, in, 1: single-cycle pulse that begins a full-store load at address 0.
- `load_valid_i`, in, 1: `load_data_i` holds a word.
- `load_data_i`, in, DATA_W: word to store.
- `load_ready_o`, out, 1: loader will accept a word this cycle.
- `load_done_o`, out, 1: single-cycle pulse after the last word is written.
- `cpu_hold_o`, out, 1: top level ORs this into the CPU reset while a load is in progress.

## Operation
- Storage is a flop array of 2^ADDR_W × DATA_W bits.
  - Cleared to 0 on reset.
- Loader FSM has three states: IDLE, LOAD and DONE.
  - IDLE → LOAD when `load_start_i`=1. Pointer is set to 0.
  - In LOAD, `load_ready_o`=1. When `load_valid_i`&`load_ready_o`, `load_data_i` is written at the pointer and the pointer increments.
  - LOAD → DONE on acceptance at pointer = 2^ADDR_W−1. The pointer wraps to 0.
  - DONE → IDLE unconditionally. `load_done_o`=1 only in DONE.
  - `load_start_i` in LOAD or DONE restarts: state goes to LOAD and the pointer to 0. A word accepted in that same cycle is still written at the old pointer.
- `cpu_hold_o` = 1 in LOAD and DONE, 0 in IDLE.
- CPU access:
  - CPU write: when state=IDLE and `ram_rw_en_i`=1, `ram_data_i` is written at `ram_addr_i` on the clock edge.
  - CPU writes in LOAD or DONE are ignored.
  - Only one write port exists. A CPU write and a loader write never occur together, because of the state gating.
- Reads are synchronous in every state. On each edge, `ram_data_o` ← mem[`ram_addr_i`].
- Read-during-write to the same address returns the old contents.
- Reset value of every output is 0: `ram_data_o`, `load_ready_o`, `load_done_o`, `cpu_hold_o`. State resets to IDLE and the pointer to 0.
- Reset asserted mid-load aborts the load. Memory is cleared, and no `load_done_o` is produced.

## Timing
- Read latency is 1 cycle: address presented at edge N gives data at `ram_data_o` after edge N.
- A write at edge N is visible to a read addressed at edge N+1.
- Loader throughput is 1 word per cycle. A minimum full load is 2^ADDR_W cycles in LOAD plus 1 cycle in DONE.
- `load_ready_o` is a registered decode of state and does not depend combinationally on `load_valid_i`.
- `cpu_hold_o` rises on the edge after `load_start_i` and falls on the edge after DONE.

## Structure
- Shared package `baby_pkg` holds:
  - `STORE_ADDR_W`=5 and `STORE_DATA_W`=32, used as the defaults for the parameters.
  - The `load_state_t` enum: IDLE, LOAD, DONE.
- One natural sub-module, `baby_store_loader`, contains the FSM, pointer, handshake, and the write-enable/address/data outputs to the array.
- `baby_store` contains the array, the write mux (loader vs CPU) and the registered read.

## Test plan
- **Reset check:** assert `reset_ni`=0 then release. Then read addresses 0..31 → `ram_data_o`=0 one cycle after each address; all outputs 0.
- **CPU write/read:** CPU writes 0xDEADBEEF at address 7 with `rw`=1, then reads 7 the next cycle → 0xDEADBEEF one cycle later. Read of 7 in the same cycle as the write returns the old value 0.
- **Full load:** `load_start_i` pulse, then 32 back-to-back words with value = address × 0x01010101. Expect:
  - `load_ready_o`=1 for 32 cycles.
  - `load_done_o` pulses exactly once.
  - `cpu_hold_o` high for 33 cycles.
  - Readback matches.
- **Stalled load:** `load_valid_i` toggles every other cycle → all words land at sequential addresses; no skips or duplicates.
- **CPU write during load:** `ram_rw_en_i`=1 with data 0xFFFFFFFF at address 3 while in LOAD → ignored; address 3 holds the loader word.
- **Restart and abort:**
  - `load_start_i` after 10 words → pointer restarts at 0 and 32 further words are required before `load_done_o`.
  - Reset after 5 words → memory reads 0 and no `load_done_o`.
